fifo_wr_frontend: RTL and testbench

FIFO_WR_FRONTEND -- requirements
Module: fifo_wr_frontend

---
 rtl/fifo_wr_frontend.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_frontend.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_frontend.sv
// Write-side front end of an async FIFO: rptr synchronizer, fill level / almost-full,
// and a two-entry skid buffer driving winc/wdata. Optional stall counter: WR_STALL_CNT_EN.
module fifo_wr_frontend #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic                  full,
    output logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  almost_full
`ifdef WR_STALL_CNT_EN
    ,
    output logic [7:0]            stall_cnt
`endif
);

    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b = '0;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two plain flops; the first may go metastable, nothing reads it but the second.
    logic [ADDR_WIDTH:0] sync1_q;
    logic [ADDR_WIDTH:0] rptr_sync_q;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            rptr_sync_q <= '0;
        end else begin
            sync1_q     <= rptr_gray;
            rptr_sync_q <= sync1_q;
        end
    end

    assign rptr_sync = rptr_sync_q;

    // Level and almost-full come from the same subtraction and update on the same edge.
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] wlevel_d;
    logic [ADDR_WIDTH:0] wlevel_q;
    logic                almost_full_d;
    logic                almost_full_q;

    always_comb begin
        wbin          = gray2bin(wptr);
        rbin          = gray2bin(rptr_sync_q);
        wlevel_d      = wbin - rbin;
        almost_full_d = (wlevel_d >= AF_LVL);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wlevel_q      <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;

    // Handshake: a word moves upstream->buffer on any edge where s_valid & s_ready are
    // both 1; s_valid/s_data must hold until then. Downstream, winc=1 means wdata is
    // consumed on this edge; wdata/winc hold while full=1.
    logic                  ovalid_q, ovalid_d;
    logic [DATA_WIDTH-1:0] odata_q,  odata_d;
    logic                  kvalid_q, kvalid_d;
    logic [DATA_WIDTH-1:0] kdata_q,  kdata_d;
    logic                  s_ready_q;
    logic                  accept;
    logic                  out_load;

    assign winc     = ovalid_q & ~full;
    assign wdata    = odata_q;
    assign s_ready  = s_ready_q;
    assign accept   = s_valid & s_ready_q;
    assign out_load = ~ovalid_q | winc;

    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        kvalid_d = kvalid_q;
        kdata_d  = kdata_q;
        if (out_load) begin
            if (kvalid_q) begin
                ovalid_d = 1'b1;
                odata_d  = kdata_q;
                kvalid_d = accept;
                if (accept) begin
                    kdata_d = s_data;
                end
            end else if (accept) begin
                ovalid_d = 1'b1;
                odata_d  = s_data;
            end else begin
                ovalid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new word behind it.
            kvalid_d = 1'b1;
            kdata_d  = s_data;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            ovalid_q  <= 1'b0;
            odata_q   <= '0;
            kvalid_q  <= 1'b0;
            kdata_q   <= '0;
            s_ready_q <= 1'b1;
        end else begin
            ovalid_q  <= ovalid_d;
            odata_q   <= odata_d;
            kvalid_q  <= kvalid_d;
            kdata_q   <= kdata_d;
            s_ready_q <= ~kvalid_d;
        end
    end

`ifdef WR_STALL_CNT_EN
    logic [7:0] stall_cnt_q;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (s_valid && !s_ready_q && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Randomized bench for fifo_wr_frontend against a queue-based model of the buffer
// and a delay-line model of the level computation.
module tb_fifo_wr_frontend;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int PW = AW + 1;
    localparam int AF = 6;

    logic          wclk;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wptr;
    logic          full;
    logic [PW-1:0] rptr_sync;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [PW-1:0] wlevel;
    logic          almost_full;
`ifdef WR_STALL_CNT_EN
    logic [7:0]    stall_cnt;
`endif

    fifo_wr_frontend #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_THRESH(AF)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .rptr_gray   (rptr_gray),
        .wptr        (wptr),
        .full        (full),
        .rptr_sync   (rptr_sync),
        .winc        (winc),
        .wdata       (wdata),
        .wlevel      (wlevel),
        .almost_full (almost_full)
`ifdef WR_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // clock / reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // scoreboard state
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [PW-1:0] rb_s1, rb_s2;
    int            exp_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock cycle: drive, check the buffer outputs before the edge, update the model
    // across the edge, then check the registered level outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic f,
                        input logic [PW-1:0] rb, input logic [PW-1:0] wb);
        logic          do_wr;
        logic          do_acc;
        logic [PW-1:0] exp_lvl;
        s_valid   = v;
        s_data    = d;
        full      = f;
        rptr_gray = b2g(rb);
        wptr      = b2g(wb);
        @(negedge wclk);
        do_wr  = (exp_q.size() > 0) && !f;
        do_acc = v && (exp_q.size() < 2);
        check_eq("s_ready", s_ready, exp_q.size() < 2);
        check_eq("winc", winc, do_wr);
        if (exp_q.size() > 0) check_eq("wdata", wdata, exp_q[0]);
        if (v && exp_q.size() >= 2 && exp_stall < 255) exp_stall++;
        @(posedge wclk);
        #1;
        if (do_wr)  void'(exp_q.pop_front());
        if (do_acc) exp_q.push_back(d);
        exp_lvl = wb - rb_s2;
        rb_s2   = rb_s1;
        rb_s1   = rb;
        check_eq("rptr_sync", rptr_sync, b2g(rb_s2));
        check_eq("wlevel", wlevel, exp_lvl);
        check_eq("almost_full", almost_full, exp_lvl >= AF);
`ifdef WR_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, exp_stall);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        rb_s1     = '0;
        rb_s2     = '0;
        exp_stall = 0;
    endtask

    task automatic do_reset();
        s_valid   = 1'b0;
        s_data    = '0;
        full      = 1'b0;
        rptr_gray = '0;
        wptr      = '0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        check_eq("rst_winc", winc, 0);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_wlevel", wlevel, 0);
        check_eq("rst_af", almost_full, 0);
        check_eq("rst_rptr_sync", rptr_sync, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic          v, f;
        logic [PW-1:0] rb, wb;
        do_reset();

        // burst of eight words, nothing blocking
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 4'd0, 4'd0);
        check_eq("burst_last_wdata", wdata, 8'h18);
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

        // full stall with skid absorb, then release
        step(1'b1, 8'hA1, 1'b0, 4'd0, 4'd0);
        step(1'b1, 8'hA2, 1'b1, 4'd0, 4'd0);
        step(1'b1, 8'hA3, 1'b1, 4'd0, 4'd0);
        step(1'b1, 8'hA3, 1'b1, 4'd0, 4'd0);
        check_eq("stall_hold_wdata", wdata, 8'hA1);
        check_eq("stall_s_ready", s_ready, 0);
        step(1'b1, 8'hA3, 1'b0, 4'd0, 4'd0);
        step(1'b1, 8'hA3, 1'b0, 4'd0, 4'd0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

        // level thresholds
        repeat (4) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd6);
        check_eq("lvl6", wlevel, 6);
        check_eq("af_at6", almost_full, 1);
        repeat (4) step(1'b0, 8'h00, 1'b0, 4'd2, 4'd6);
        check_eq("lvl4", wlevel, 4);
        check_eq("af_at4", almost_full, 0);

        // pointer wrap
        repeat (4) step(1'b0, 8'h00, 1'b0, 4'd13, 4'd1);
        check_eq("lvl_wrap", wlevel, 4);

        // long stall: saturates the optional counter, output must stay frozen
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 4'd0, 4'd0);
`ifdef WR_STALL_CNT_EN
        check_eq("stall_sat", stall_cnt, 255);
`endif
        repeat (4) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

        // randomized traffic
        rb = '0;
        wb = '0;
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) wb = 4'($urandom_range(0, 15));
            step(v, 8'($urandom_range(0, 255)), f, rb, wb);
        end

        // asynchronous reset with both entries occupied
        step(1'b1, 8'hC1, 1'b1, 4'd0, 4'd0);
        step(1'b1, 8'hC2, 1'b1, 4'd0, 4'd0);
        step(1'b1, 8'hC3, 1'b1, 4'd0, 4'd0);
        full = 1'b0;
        @(negedge wclk);
        check_eq("pre_rst_winc", winc, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_winc", winc, 0);
        check_eq("async_rst_s_ready", s_ready, 1);
        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
        step(1'b1, 8'h5A, 1'b0, 4'd0, 4'd0);
        step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
